ps2_io_port: RTL and testbench
==============================

PS2_IO_PORT -- requirements
Module: ps2_io_port

Interface
REQ-001: Parameter DEPTH, default 4, number of 32-bit words held in the receive FIFO; power of two, 2..16.
REQ-002: clk  input  1  system clock; all logic updates on rising edge.
REQ-003: reset  input  1  synchronous, active-low reset; sampled on rising edge of clk.
REQ-004: joi  input  32  assembled 4-byte word from the PS/2 peripheral.
REQ-005: listo  input  1  word-ready flag from the PS/2 peripheral; held high while joi valid.
REQ-006: addr  input  2  CPU register select: 0 DATA, 1 STATUS, 2 CONTROL, 3 reserved.
REQ-007: rd_strobe  input  1  one-cycle CPU read request.
REQ-008: wr_strobe  input  1  one-cycle CPU write request.
REQ-009: wr_data  input  8  CPU write data (CONTROL only).
REQ-010: rd_data  output  32  registered CPU read data.
REQ-011: rx_en  output  1  receive enable to the PS/2 peripheral.
REQ-012: irq  output  1  registered interrupt request, level.

Function
REQ-013: Capture: a push SHALL occur on each cycle where listo=1 and listo_prev=0; listo_prev is a register of listo.
- Push writes joi into FIFO tail; one push per listo rising edge regardless of how long listo stays high.
REQ-014: FIFO SHALL be circular, DEPTH entries, read/write pointers wrap DEPTH-1 -> 0; count width clog2(DEPTH)+1.
REQ-015: Push when full SHALL drop the word, leave FIFO unchanged, and set sticky overflow=1.
REQ-016: DATA read (rd_strobe=1, addr=0): if non-empty, rd_data<=head word next cycle and head popped same edge; if empty, rd_data<=0, no pop, no error.
REQ-017: STATUS read: rd_data<= {zeros, overflow[7], count[6:2] zero-extended (count width ≤5), full[1], empty[0]}; no side effects.
REQ-018: CONTROL read: rd_data<= {zeros, irq_en[1], rx_enable[0]}; addr=3 read returns 0.
REQ-019: Read latency SHALL be exactly 1 cycle; rd_data holds its value until the next rd_strobe.
REQ-020: CONTROL write (wr_strobe=1, addr=2): bit0 -> rx_enable, bit1 -> irq_en, bit2=1 -> flush (pointers, count, overflow cleared); bit2 is self-clearing, not stored. Writes to other addresses ignored.
REQ-021: Simultaneous push and pop (non-full, non-empty) SHALL both complete; count unchanged.
REQ-022: Simultaneous push and pop when full: pop completes, push also completes (slot freed same edge), no overflow.
REQ-023: Simultaneous push and pop when empty: pop returns 0, push stores word; count becomes 1.
REQ-024: Flush simultaneous with push or pop: flush wins; FIFO empty, overflow 0 afterward; a simultaneous DATA read returns 0.
REQ-025: rx_en SHALL be registered: rx_en <= rx_enable & ~full_next, where full_next is the post-update full state.
REQ-026: irq SHALL be registered: irq <= irq_en & ~empty_next; deasserts the cycle after the pop that empties the FIFO.
REQ-027: rd_strobe and wr_strobe both high: both actions SHALL execute in the same cycle.

Reset
REQ-028: With reset=0 at a rising edge: pointers=0, count=0, overflow=0, listo_prev=0, rx_enable=1, irq_en=0, rd_data=0, rx_en=1, irq=0.
REQ-029: Reset mid-operation SHALL discard FIFO contents; a listo already high on the first cycle after release counts as a rising edge and pushes once.

Verification
REQ-030: Pulse listo with joi=0x1C_F0_1C_00, then DATA read -> rd_data=0x1CF01C00 one cycle after strobe; STATUS read then -> empty=1, count=0.
REQ-031: Hold listo high 10 cycles -> exactly one push, count=1.
REQ-032: DEPTH=4, 5 listo edges with joi=1..5 -> full=1, rx_en=0, overflow=1; 4 DATA reads return 1,2,3,4, 5th read returns 0.
REQ-033: Write CONTROL=0x02, push one word -> irq=1 next cycle; DATA read -> irq=0 the cycle after pop.
REQ-034: FIFO full, listo edge coincident with DATA read -> read returns oldest word, new word stored, count=4, overflow=0.
REQ-035: 3 words queued, write CONTROL=0x05 coincident with listo edge -> count=0, overflow=0, rx_en=1; following DATA read returns 0.

Source files
------------

// File: rtl/ps2_io_port.sv
// CPU-facing register port for a PS/2 receiver: captures one 32-bit word per
// listo rising edge into a circular FIFO and exposes DATA/STATUS/CONTROL registers.
module ps2_io_port #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] joi,
    input  logic        listo,
    input  logic [1:0]  addr,
    input  logic        rd_strobe,
    input  logic        wr_strobe,
    input  logic [7:0]  wr_data,
    output logic [31:0] rd_data,
    output logic        rx_en,
    output logic        irq
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    localparam logic [1:0] A_DATA   = 2'd0;
    localparam logic [1:0] A_STATUS = 2'd1;
    localparam logic [1:0] A_CTRL   = 2'd2;

    logic [31:0]   r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_ovf;
    logic          r_listo_prev;
    logic          r_rx_enable;
    logic          r_irq_en;

    logic          w_empty;
    logic          w_full;
    logic          w_push_req;
    logic          w_flush;
    logic          w_ctrl_wr;
    logic          w_data_rd;
    logic          w_pop;
    logic          w_push;
    logic          w_ovf_set;
    logic [CW-1:0] w_count_next;
    logic          w_full_next;
    logic          w_empty_next;
    logic          w_rx_enable_next;
    logic          w_irq_en_next;
    logic [4:0]    w_count5;
    logic [31:0]   w_status;
    logic [31:0]   w_rd_next;
    logic          w_unused;

    assign w_unused = &{1'b0, wr_data[7:3]};

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == CW'(DEPTH));
    assign w_push_req = listo & ~r_listo_prev;
    assign w_ctrl_wr  = wr_strobe & (addr == A_CTRL);
    assign w_flush    = w_ctrl_wr & wr_data[2];
    assign w_data_rd  = rd_strobe & (addr == A_DATA);

    // A pop frees the head slot on the same edge, so a full FIFO can still
    // accept a coincident push; flush overrides both.
    assign w_pop     = w_data_rd & ~w_empty & ~w_flush;
    assign w_push    = w_push_req & ~w_flush & (~w_full | w_pop);
    assign w_ovf_set = w_push_req & ~w_flush & w_full & ~w_pop;

    always_comb begin
        w_count_next = r_count;
        if (w_flush)
            w_count_next = '0;
        else if (w_push && !w_pop)
            w_count_next = r_count + 1'b1;
        else if (w_pop && !w_push)
            w_count_next = r_count - 1'b1;
    end

    assign w_full_next      = (w_count_next == CW'(DEPTH));
    assign w_empty_next     = (w_count_next == '0);
    assign w_rx_enable_next = w_ctrl_wr ? wr_data[0] : r_rx_enable;
    assign w_irq_en_next    = w_ctrl_wr ? wr_data[1] : r_irq_en;

    assign w_count5 = 5'(r_count);
    assign w_status = {24'd0, r_ovf, w_count5, w_full, w_empty};

    always_comb begin
        w_rd_next = rd_data;
        if (rd_strobe) begin
            case (addr)
                A_DATA:   w_rd_next = w_pop ? r_mem[r_rptr] : 32'd0;
                A_STATUS: w_rd_next = w_status;
                A_CTRL:   w_rd_next = {30'd0, r_irq_en, r_rx_enable};
                default:  w_rd_next = 32'd0;
            endcase
        end
    end

    // Storage carries no reset: contents are only visible through count/pointers.
    always_ff @(posedge clk) begin
        if (reset && w_push)
            r_mem[r_wptr] <= joi;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_ovf        <= 1'b0;
            r_listo_prev <= 1'b0;
            r_rx_enable  <= 1'b1;
            r_irq_en     <= 1'b0;
            rd_data      <= 32'd0;
            rx_en        <= 1'b1;
            irq          <= 1'b0;
        end else begin
            r_listo_prev <= listo;
            r_count      <= w_count_next;
            r_rx_enable  <= w_rx_enable_next;
            r_irq_en     <= w_irq_en_next;
            rd_data      <= w_rd_next;
            rx_en        <= w_rx_enable_next & ~w_full_next;
            irq          <= w_irq_en_next & ~w_empty_next;
            if (w_flush) begin
                r_wptr <= '0;
                r_rptr <= '0;
                r_ovf  <= 1'b0;
            end else begin
                if (w_push)
                    r_wptr <= r_wptr + 1'b1;
                if (w_pop)
                    r_rptr <= r_rptr + 1'b1;
                if (w_ovf_set)
                    r_ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ps2_io_port.sv
// Bench for ps2_io_port: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ps2_io_port;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic [31:0] joi;
    logic        listo;
    logic [1:0]  addr;
    logic        rd_strobe;
    logic        wr_strobe;
    logic [7:0]  wr_data;
    logic [31:0] rd_data;
    logic        rx_en;
    logic        irq;

    int checks = 0;
    int errors = 0;

    ps2_io_port #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .joi(joi), .listo(listo), .addr(addr),
        .rd_strobe(rd_strobe), .wr_strobe(wr_strobe), .wr_data(wr_data),
        .rd_data(rd_data), .rx_en(rx_en), .irq(irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the FIFO is a plain queue; each edge reads, then pops,
    // then pushes, with flush discarding everything.
    logic [31:0] mq[$];
    logic        m_ovf, m_lp, m_rxe, m_ie, m_valid;
    logic [31:0] m_rd;
    logic        m_rx_en, m_irq;

    initial m_valid = 1'b0;

    always @(posedge clk) begin : model
        logic        push_req, flush, cwr;
        logic [31:0] nxt;
        m_valid <= 1'b1;
        if (!reset) begin
            mq.delete();
            m_ovf = 0; m_lp = 0; m_rxe = 1; m_ie = 0;
            m_rd = 0; m_rx_en = 1; m_irq = 0;
        end else begin
            push_req = listo && !m_lp;
            m_lp     = listo;
            cwr      = wr_strobe && addr == 2;
            flush    = cwr && wr_data[2];
            nxt      = m_rd;
            if (rd_strobe) begin
                case (addr)
                    2'd0: nxt = (!flush && mq.size() > 0) ? mq[0] : 32'd0;
                    2'd1: nxt = (m_ovf ? 32'h80 : 32'h0) + 32'(mq.size()) * 4
                                + (mq.size() == DEPTH ? 32'h2 : 32'h0)
                                + (mq.size() == 0 ? 32'h1 : 32'h0);
                    2'd2: nxt = {30'd0, m_ie, m_rxe};
                    default: nxt = 32'd0;
                endcase
                if (addr == 0 && !flush && mq.size() > 0) void'(mq.pop_front());
            end
            m_rd = nxt;
            if (flush) begin
                mq.delete();
                m_ovf = 0;
            end else if (push_req) begin
                if (mq.size() < DEPTH) mq.push_back(joi);
                else m_ovf = 1;
            end
            if (cwr) begin
                m_rxe = wr_data[0];
                m_ie  = wr_data[1];
            end
            m_rx_en = m_rxe && (mq.size() != DEPTH);
            m_irq   = m_ie && (mq.size() != 0);
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_rd_data", rd_data, m_rd);
            chk("model_rx_en", {31'd0, rx_en}, {31'd0, m_rx_en});
            chk("model_irq", {31'd0, irq}, {31'd0, m_irq});
        end
    end

    task automatic idle(input int n);
        rd_strobe = 0; wr_strobe = 0; listo = 0;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic [31:0] w);
        joi = w; listo = 1;
        @(negedge clk);
        listo = 0;
        @(negedge clk);
    endtask

    task automatic rd(input logic [1:0] a);
        addr = a; rd_strobe = 1;
        @(negedge clk);
        rd_strobe = 0;
    endtask

    task automatic wr(input logic [7:0] d);
        addr = 2; wr_data = d; wr_strobe = 1;
        @(negedge clk);
        wr_strobe = 0;
    endtask

    initial begin
        reset = 0; joi = 0; listo = 0; addr = 0;
        rd_strobe = 0; wr_strobe = 0; wr_data = 0;
        repeat (2) @(negedge clk);
        chk("reset_rd_data", rd_data, 32'h0);
        chk("reset_rx_en", {31'd0, rx_en}, 32'h1);
        chk("reset_irq", {31'd0, irq}, 32'h0);
        reset = 1;
        @(negedge clk);
        rd(1); chk("reset_status", rd_data, 32'h1);
        rd(2); chk("reset_ctrl", rd_data, 32'h1);

        // single word round trip
        pulse(32'h1CF01C00);
        rd(0); chk("basic_data", rd_data, 32'h1CF01C00);
        rd(1); chk("basic_status", rd_data, 32'h1);

        // long listo pulse pushes once
        joi = 32'hCAFE0001; listo = 1;
        repeat (10) @(negedge clk);
        listo = 0; @(negedge clk);
        rd(1); chk("hold_status", rd_data, 32'h4);
        rd(0); chk("hold_data", rd_data, 32'hCAFE0001);

        // overflow on the fifth push
        for (int i = 1; i <= 5; i++) pulse(32'(i));
        chk("ovf_rx_en", {31'd0, rx_en}, 32'h0);
        rd(1); chk("ovf_status", rd_data, 32'h92);
        for (int i = 1; i <= 4; i++) begin
            rd(0); chk("ovf_drain", rd_data, 32'(i));
        end
        rd(0); chk("ovf_empty_read", rd_data, 32'h0);
        rd(1); chk("ovf_sticky", rd_data, 32'h81);
        wr(8'h05);
        rd(1); chk("flush_clears_ovf", rd_data, 32'h1);

        // interrupt follows occupancy
        wr(8'h02);
        joi = 32'h00000077; listo = 1;
        @(negedge clk);
        chk("irq_set", {31'd0, irq}, 32'h1);
        listo = 0; @(negedge clk);
        rd(0);
        chk("irq_data", rd_data, 32'h77);
        chk("irq_clear", {31'd0, irq}, 32'h0);

        // full FIFO, push coincident with pop
        wr(8'h03);
        for (int i = 0; i < 4; i++) pulse(32'hA0 + 32'(i));
        joi = 32'hA4; listo = 1; addr = 0; rd_strobe = 1;
        @(negedge clk);
        rd_strobe = 0; listo = 0;
        chk("fullpp_data", rd_data, 32'hA0);
        @(negedge clk);
        rd(1); chk("fullpp_status", rd_data, 32'h12);
        for (int i = 1; i <= 4; i++) begin
            rd(0); chk("fullpp_drain", rd_data, 32'hA0 + 32'(i));
        end

        // empty FIFO, push coincident with pop
        joi = 32'h55; listo = 1; addr = 0; rd_strobe = 1;
        @(negedge clk);
        rd_strobe = 0; listo = 0;
        chk("emptypp_data", rd_data, 32'h0);
        rd(1); chk("emptypp_status", rd_data, 32'h4);
        rd(0); chk("emptypp_pop", rd_data, 32'h55);

        // flush wins over a coincident push
        for (int i = 0; i < 3; i++) pulse(32'hB0 + 32'(i));
        joi = 32'hBB; listo = 1; addr = 2; wr_data = 8'h05; wr_strobe = 1;
        @(negedge clk);
        wr_strobe = 0; listo = 0;
        chk("flush_rx_en", {31'd0, rx_en}, 32'h1);
        @(negedge clk);
        rd(1); chk("flush_status", rd_data, 32'h1);
        rd(0); chk("flush_data", rd_data, 32'h0);

        // reset mid-operation with listo held through release
        pulse(32'hD0); pulse(32'hD1);
        joi = 32'hD2; listo = 1; reset = 0;
        repeat (2) @(negedge clk);
        reset = 1;
        @(negedge clk);
        listo = 0; @(negedge clk);
        rd(1); chk("rst_listo_status", rd_data, 32'h4);
        rd(0); chk("rst_listo_data", rd_data, 32'hD2);

        // randomized traffic; the model compare process covers every cycle
        for (int c = 0; c < 4000; c++) begin
            logic [7:0] d;
            reset     = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 2) == 0) listo = ~listo;
            joi       = $urandom;
            addr      = 2'($urandom_range(0, 3));
            rd_strobe = ($urandom_range(0, 2) == 0);
            wr_strobe = ($urandom_range(0, 9) == 0);
            d         = 8'($urandom);
            if ($urandom_range(0, 5) != 0) d[2] = 1'b0;
            wr_data   = d;
            @(negedge clk);
        end
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
